// File: rtl/pararam_pkg.sv
// Shared types and constants for the ParaRAM host command front-end.
// Opcode layout: bit7 = write, bit6 = burst, low bits = start address.
package pararam_pkg;

    localparam int ADDR_WIDTH_DEF = 6;
    localparam int DATA_WIDTH_DEF = 24;

    localparam int OP_WR    = 7;
    localparam int OP_BURST = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_WDATA,
        S_WRITE,
        S_RREQ,
        S_RWAIT,
        S_RSEND
    } state_t;

    function automatic int bytes_of(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/pararam_host_ctrl_if.sv
// Command/response byte streams plus the ParaRAM memory port.
// The slave side is the controller; the master side is host plus RAM.
interface pararam_host_ctrl_if import pararam_pkg::*; #(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [7:0]            out_data;
    logic                  out_ready;
    logic                  mem_en;
    logic                  mem_wc;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output in_valid, in_data, out_ready, mem_rdata,
        input  in_ready, out_valid, out_data, mem_en, mem_wc, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data, out_ready, mem_rdata,
        output in_ready, out_valid, out_data, mem_en, mem_wc, mem_addr, mem_wdata
    );

endinterface

// File: rtl/pararam_host_ctrl.sv
// Byte-stream command front-end for ParaRAM: collects write words, sequences
// single-cycle RAM accesses and serialises read words MSB first.
module pararam_host_ctrl import pararam_pkg::*; #(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    pararam_host_ctrl_if.slave  bus,
    output logic                busy
);

    localparam int              BYTES     = bytes_of(DATA_WIDTH);
    localparam int              BCW       = $clog2(BYTES) + 1;
    localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BYTES - 1);

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            cnt;     // words still to do after the current one
    logic [BCW-1:0]        bcnt;
    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] sr_in;
    logic                  is_wr;
    logic                  in_fire, out_fire, last_byte, last_word;

    assign bus.in_ready  = rst_n && (state == S_IDLE || state == S_LEN || state == S_WDATA);
    assign bus.out_valid = (state == S_RSEND);
    assign bus.out_data  = sr[DATA_WIDTH-1 -: 8];
    assign busy          = (state != S_IDLE);

    assign in_fire   = bus.in_valid && bus.in_ready;
    assign out_fire  = bus.out_valid && bus.out_ready;
    assign sr_in     = (sr << 8) | DATA_WIDTH'(bus.in_data);
    assign last_byte = (bcnt == LAST_BYTE);
    assign last_word = (cnt == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:
                if (bus.in_valid) begin
                    if (bus.in_data[OP_BURST])  state_nx = S_LEN;
                    else if (bus.in_data[OP_WR]) state_nx = S_WDATA;
                    else                         state_nx = S_RREQ;
                end
            S_LEN:
                if (bus.in_valid) state_nx = is_wr ? S_WDATA : S_RREQ;
            S_WDATA:
                if (bus.in_valid && last_byte) state_nx = S_WRITE;
            S_WRITE:
                state_nx = last_word ? S_IDLE : S_WDATA;
            S_RREQ:
                state_nx = S_RWAIT;
            // First RWAIT cycle carries the strobe; the second waits for read data.
            S_RWAIT:
                if (!bus.mem_en) state_nx = S_RSEND;
            S_RSEND:
                if (bus.out_ready && last_byte) state_nx = last_word ? S_IDLE : S_RREQ;
            default:
                state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr          <= '0;
            cnt           <= '0;
            bcnt          <= '0;
            sr            <= '0;
            is_wr         <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_wc    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_en <= 1'b0;
            bus.mem_wc <= 1'b0;
            case (state)
                S_IDLE:
                    if (in_fire) begin
                        addr  <= bus.in_data[ADDR_WIDTH-1:0];
                        is_wr <= bus.in_data[OP_WR];
                        cnt   <= '0;
                        bcnt  <= '0;
                    end
                S_LEN:
                    if (in_fire) cnt <= bus.in_data;
                S_WDATA:
                    if (in_fire) begin
                        sr   <= sr_in;
                        bcnt <= last_byte ? '0 : bcnt + 1'b1;
                        if (last_byte) begin
                            bus.mem_en    <= 1'b1;
                            bus.mem_wc    <= 1'b1;
                            bus.mem_addr  <= addr;
                            bus.mem_wdata <= sr_in;
                        end
                    end
                S_WRITE: begin
                    addr <= addr + 1'b1;
                    if (!last_word) cnt <= cnt - 8'd1;
                end
                S_RREQ: begin
                    bus.mem_en   <= 1'b1;
                    bus.mem_addr <= addr;
                end
                S_RWAIT:
                    if (!bus.mem_en) sr <= bus.mem_rdata;
                S_RSEND:
                    if (out_fire) begin
                        sr   <= sr << 8;
                        bcnt <= last_byte ? '0 : bcnt + 1'b1;
                        if (last_byte) begin
                            addr <= addr + 1'b1;
                            if (!last_word) cnt <= cnt - 8'd1;
                        end
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pararam_host_ctrl.sv
// Scoreboard bench for pararam_host_ctrl with a registered-read RAM model.
module tb_pararam_host_ctrl;
    import pararam_pkg::*;

    localparam int AW = 6;
    localparam int DW = 24;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    pararam_host_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    pararam_host_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    wr_t           exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    logic [7:0]    exp_byte[$];
    logic [DW-1:0] mem [64];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int en_cnt = 0;
    int acc_cyc = 0;

    // RAM model: read data registered on the strobe edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_en && !bus.mem_wc) bus.mem_rdata <= mem[bus.mem_addr];
    end

    always @(negedge clk) begin : monitor
        wr_t           w;
        logic [AW-1:0] a;
        logic [7:0]    b;
        if (rst_n) begin
            if (bus.mem_en) begin
                en_cnt++;
                checks++;
                if (bus.mem_wc) begin
                    if (exp_wr.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write addr=%0d data=%h", bus.mem_addr, bus.mem_wdata);
                    end else begin
                        w = exp_wr.pop_front();
                        if (bus.mem_addr !== w.addr || bus.mem_wdata !== w.data) begin
                            errors++;
                            $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                                     bus.mem_addr, bus.mem_wdata, w.addr, w.data);
                        end
                    end
                end else begin
                    if (exp_rd.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_read addr=%0d", bus.mem_addr);
                    end else begin
                        a = exp_rd.pop_front();
                        if (bus.mem_addr !== a) begin
                            errors++;
                            $display("FAIL read_addr got %0d want %0d", bus.mem_addr, a);
                        end
                    end
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_byte.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out_byte got %h", bus.out_data);
                end else begin
                    b = exp_byte.pop_front();
                    if (bus.out_data !== b) begin
                        errors++;
                        $display("FAIL out_byte got %h want %h", bus.out_data, b);
                    end
                end
            end
        end
    end

    function automatic logic [42:0] out_snap();
        return {bus.in_ready, bus.out_valid, bus.out_data, bus.mem_en, bus.mem_wc,
                bus.mem_addr, bus.mem_wdata, busy};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        exp_byte.push_back(w[23:16]);
        exp_byte.push_back(w[15:8]);
        exp_byte.push_back(w[7:0]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte=%h in_ready=%b want 1", b, bus.in_ready);
        end
        @(posedge clk);
        #1;
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 500);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout busy=%b want 0", busy);
        end
        tick(1);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (out_snap() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", out_snap());
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_in_ready got %b want 1", bus.in_ready);
        end
        tick(1);
    endtask

    task automatic test_single_write();
        int e0;
        e0 = en_cnt;
        exp_wr.push_back('{addr: 6'd5, data: 24'hABCDEF});
        send_byte(8'h85);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'hEF);
        // strobe must already be up in the cycle after the last byte's edge
        @(negedge clk);
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_wc !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_timing en=%b wc=%b in_ready=%b want 1 1 0",
                     bus.mem_en, bus.mem_wc, bus.in_ready);
        end
        wait_idle();
        tick(2);
        checks++;
        if (en_cnt - e0 !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL write_strobe_count got %0d busy=%b want 1 busy=0", en_cnt - e0, busy);
        end
    endtask

    task automatic test_single_read();
        int n;
        exp_rd.push_back(6'd5);
        push_word(24'h123456);
        send_byte(8'h05);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_en && n < 20);
        checks++;
        if (cyc - acc_cyc !== 1 || bus.mem_wc !== 1'b0) begin
            errors++;
            $display("FAIL read_strobe_latency got %0d wc=%b want 1 wc=0", cyc - acc_cyc, bus.mem_wc);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        checks++;
        if (cyc - acc_cyc !== 3) begin
            errors++;
            $display("FAIL read_out_latency got %0d want 3", cyc - acc_cyc);
        end
        wait_idle();
    endtask

    task automatic test_burst_wrap();
        int e0;
        e0 = en_cnt;
        exp_wr.push_back('{addr: 6'd62, data: 24'h010203});
        exp_wr.push_back('{addr: 6'd63, data: 24'h040506});
        exp_wr.push_back('{addr: 6'd0,  data: 24'h070809});
        send_byte(8'hFE);
        send_byte(8'h02);
        for (int i = 1; i <= 9; i++) send_byte(8'(i));
        wait_idle();
        checks++;
        if (en_cnt - e0 !== 3) begin
            errors++;
            $display("FAIL burst_strobe_count got %0d want 3", en_cnt - e0);
        end
    endtask

    task automatic test_backpressure();
        int e0;
        int n;
        e0 = en_cnt;
        bus.out_ready = 1'b0;
        exp_rd.push_back(6'd10);
        exp_rd.push_back(6'd11);
        push_word(24'h123456);
        push_word(24'h789ABC);
        send_byte(8'h4A);
        send_byte(8'h01);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h12 || en_cnt - e0 !== 1) begin
                errors++;
                $display("FAIL backpressure_hold cyc%0d valid=%b data=%h strobes=%0d want 1 12 1",
                         i, bus.out_valid, bus.out_data, en_cnt - e0);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_idle();
        checks++;
        if (en_cnt - e0 !== 2) begin
            errors++;
            $display("FAIL backpressure_strobe_count got %0d want 2", en_cnt - e0);
        end
    endtask

    task automatic test_input_gaps();
        exp_wr.push_back('{addr: 6'd20, data: 24'h0F1E2D});
        send_byte(8'h94);
        tick(1);
        send_byte(8'h0F);
        tick(1);
        send_byte(8'h1E);
        tick(1);
        send_byte(8'h2D);
        @(negedge clk);
        checks++;
        if (bus.mem_en !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL gaps_write_cycle en=%b in_ready=%b want 1 0", bus.mem_en, bus.in_ready);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_burst();
        int e0;
        int n;
        bus.out_ready = 1'b0;
        exp_rd.push_back(6'd48);
        send_byte(8'h70);
        send_byte(8'h03);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_snap() !== '0) begin
            errors++;
            $display("FAIL midburst_reset_outputs got %h want 0", out_snap());
        end
        exp_byte.delete();
        tick(2);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        e0            = en_cnt;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.mem_en !== 1'b0) begin
            errors++;
            $display("FAIL midburst_release in_ready=%b busy=%b en=%b want 1 0 0",
                     bus.in_ready, busy, bus.mem_en);
        end
        tick(4);
        checks++;
        if (en_cnt !== e0) begin
            errors++;
            $display("FAIL midburst_spurious_strobe got %0d want 0", en_cnt - e0);
        end
        exp_rd.push_back(6'd7);
        push_word(24'hA5C3E1);
        send_byte(8'h07);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 24'(i * 3);
        mem[5]  = 24'h123456;
        mem[7]  = 24'hA5C3E1;
        mem[10] = 24'h123456;
        mem[11] = 24'h789ABC;
        mem[48] = 24'hDEAD01;
        mem[49] = 24'hBEEF02;

        test_reset();
        test_single_write();
        test_single_read();
        test_burst_wrap();
        test_backpressure();
        test_input_gaps();
        test_reset_mid_burst();

        tick(3);
        checks++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0 || exp_byte.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations wr=%0d rd=%0d bytes=%0d want 0 0 0",
                     exp_wr.size(), exp_rd.size(), exp_byte.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pararam_host_ctrl.md
# pararam_host_ctrl

Byte-stream command front-end that sits directly upstream of the ParaRAM array and drives its memory port (clock-synchronous en / wc / addr / write-data, one-cycle registered read-data). It accepts read and write commands as a valid/ready byte stream, with optional auto-incrementing bursts. It sequences the single-cycle RAM accesses and returns read words as a valid/ready byte stream, most significant byte first.

## Interface
- ADDR_WIDTH, 6, RAM address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 24, RAM word width; must be a multiple of 8. BYTES = DATA_WIDTH/8.
- clk  in  1  clock; also the RAM clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  command byte valid.
- in_data  in  8  command byte.
- in_ready  out  1  byte accepted on a clk edge where in_valid && in_ready.
- out_valid  out  1  response byte valid.
- out_data  out  8  response byte.
- out_ready  in  1  response byte consumed on a clk edge where out_valid && out_ready.
- mem_en  out  1  RAM access strobe, registered.
- mem_wc  out  1  1 = write, 0 = read; high only when mem_en is high; registered.
- mem_addr  out  ADDR_WIDTH  RAM address, registered.
- mem_wdata  out  DATA_WIDTH  RAM write data, registered.
- mem_rdata  in  DATA_WIDTH  RAM read data; valid from the second edge after the read strobe is issued.
- busy  out  1  high in every state except IDLE.

## Operation
- Opcode byte: bit7 = WR, bit6 = BURST, bits[ADDR_WIDTH-1:0] = start address. Bits between ADDR_WIDTH and 5 are ignored.
- If BURST = 1, the next byte is LEN, and the word count is N = LEN+1 (1..256). If BURST = 0, N = 1.
- Write: N×BYTES data bytes follow, MSB first. After each full word, the block issues one write cycle, then increments the address.
- Read: for each word, the block issues one read cycle, captures mem_rdata, and emits BYTES bytes MSB first. Then it increments the address.
- Address increment is modulo 2^ADDR_WIDTH (63 → 0).
- FSM states:
  - IDLE: in_ready=1. Accepts the opcode, then goes to LEN if BURST, else WDATA if WR, else RREQ.
  - LEN: in_ready=1. Accepts LEN, then goes to WDATA or RREQ.
  - WDATA: in_ready=1. Shifts bytes in. After byte BYTES, goes to WRITE.
  - WRITE: one cycle with mem_en=1, mem_wc=1. Then goes to WDATA if words remain, else IDLE.
  - RREQ: one cycle with mem_en=1, mem_wc=0.
  - RWAIT: captures mem_rdata into the shift register at the end of this cycle.
  - RSEND: out_valid=1. Shifts on each handshake. After the last byte, goes to RREQ if words remain, else IDLE.
- in_ready is 0 in WRITE, RREQ, RWAIT, RSEND and while rst_n is low.
- Bytes are never dropped or duplicated. in_valid gaps simply stall WDATA/LEN/IDLE.
- While out_ready is low, out_valid and out_data hold stable, and no further mem_en is issued.
- mem_en is high for exactly one cycle per word. No RAM access occurs in any other state.
- Reset (any time, including mid-burst): state=IDLE; all outputs 0; partial word and remaining count discarded; no mem_en.
- After rst_n rises, in_ready=1 from the first cycle.

## Timing
- Reset values: in_ready 0 (1 once rst_n is high), out_valid 0, out_data 0, mem_en 0, mem_wc 0, mem_addr 0, mem_wdata 0, busy 0.
- Write: the last data byte is accepted at edge E, and mem_en/mem_wc/mem_addr/mem_wdata are high/valid from E to E+1.
- Write throughput: BYTES+1 cycles per word at full in_valid rate.
- Read: the opcode (or LEN) is accepted at E. mem_en is high E+1..E+2. The RAM samples at E+2. The block captures at E+3. out_valid rises at E+3 with the MSB.
- Read latency per word: 3 cycles plus BYTES handshakes.
- busy rises on the edge accepting the opcode and falls on the edge entering IDLE.

## Structure
- Package pararam_pkg holds:
  - state enum;
  - opcode bit positions (OP_WR=7, OP_BURST=6);
  - BYTES derivation;
  - shared ADDR_WIDTH/DATA_WIDTH defaults.
- Single module, no sub-modules. The byte shift register is shared by write collection and read serialization.

## Test plan
- Single write: in bytes 0x05|0x80, 0xAB, 0xCD, 0xEF → exactly one cycle with mem_en=1, mem_wc=1, mem_addr=5, mem_wdata=0xABCDEF. Then busy=0.
- Single read: in 0x05, RAM model returns 0x123456 → one mem_en cycle with mem_wc=0, addr 5. out bytes 0x12, 0x34, 0x56. out_valid first at 3 cycles after the opcode edge.
- Burst write with wrap: 0xFE, LEN 0x02, 9 data bytes → three writes at addresses 62, 63, 0 with the correct words.
- Read backpressure: burst read of 2 words with out_ready low for 5 cycles after the first byte → out_data held 0x12, and no second mem_en until the first word has fully drained.
- Input gaps: write bytes with in_valid toggling every other cycle → a single write with the correct data; in_ready is 0 during WRITE.
- Reset mid-burst: rst_n low during RSEND of word 1 of 4 → all outputs 0 immediately. After release, IDLE with in_ready=1 and no mem_en. A following single read behaves normally.
